// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and default timing.
package reset_sequencer_pkg;

    localparam int DEF_N_CHAN        = 4;
    localparam int DEF_W_CNT         = 8;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_STAGE_DELAY   = 8;
    localparam int DEF_READY_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_DELAY    = 2'd1,
        ST_WAIT_RDY = 2'd2,
        ST_RUN      = 2'd3
    } seq_state_t;

    // Width of the stage index for a given channel count.
    function automatic int stage_width(input int n_chan);
        return $clog2(n_chan) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the SoC top level.
interface reset_sequencer_if
    import reset_sequencer_pkg::*;
#(
    parameter int N_CHAN = DEF_N_CHAN
) ();

    logic                            req_reset;
    logic [N_CHAN-1:0]               chan_ready;
    logic [N_CHAN-1:0]               rst_n_out;
    logic                            busy;
    logic                            done;
    logic                            timeout_err;
    logic [stage_width(N_CHAN)-1:0]  stage;

    // Sequencer side.
    modport master (
        input  req_reset,
        input  chan_ready,
        output rst_n_out,
        output busy,
        output done,
        output timeout_err,
        output stage
    );

    // Consumer side (SoC top / subsystems).
    modport slave (
        output req_reset,
        output chan_ready,
        input  rst_n_out,
        input  busy,
        input  done,
        input  timeout_err,
        input  stage
    );

endinterface

// File: rtl/reset_sequencer.sv
// Ordered release of N_CHAN active-low resets with hold time, per-stage delay,
// optional per-channel ready handshake with timeout, and software re-sequencing.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int               N_CHAN        = DEF_N_CHAN,
    parameter int               W_CNT         = DEF_W_CNT,
    parameter int               HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int               STAGE_DELAY   = DEF_STAGE_DELAY,
    parameter int               READY_TIMEOUT = DEF_READY_TIMEOUT,
    parameter logic [N_CHAN-1:0] USE_READY    = '0
) (
    input  logic               clk_sys,
    input  logic               rst_sys,
    reset_sequencer_if.master  bus
);

    localparam int SW = stage_width(N_CHAN);
    localparam int IW = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;

    localparam logic [W_CNT-1:0] HOLD_LAST  = W_CNT'(HOLD_CYCLES - 1);
    localparam logic [W_CNT-1:0] DELAY_LAST = W_CNT'(STAGE_DELAY - 1);
    localparam logic [W_CNT-1:0] TO_LAST    = W_CNT'(READY_TIMEOUT - 1);
    localparam logic [SW-1:0]    LAST_STAGE = SW'(N_CHAN - 1);

    // Reject timing parameters the shared counter cannot represent.
    if (HOLD_CYCLES < 1 || STAGE_DELAY < 1 || READY_TIMEOUT < 0 ||
        longint'(HOLD_CYCLES)   >= (longint'(1) << W_CNT) ||
        longint'(STAGE_DELAY)   >= (longint'(1) << W_CNT) ||
        longint'(READY_TIMEOUT) >= (longint'(1) << W_CNT)) begin : g_param_err
        $error("reset_sequencer: timing parameters out of range for W_CNT");
    end

    seq_state_t         state_reg, state_next;
    logic [W_CNT-1:0]   cnt_reg, cnt_next;
    logic [SW-1:0]      stage_reg, stage_next;
    logic [N_CHAN-1:0]  rst_n_reg, rst_n_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               terr_reg, terr_next;
    logic               advance;
    logic [IW-1:0]      idx;

    // Channel index used to select per-channel ready/enable bits.
    assign idx = stage_reg[IW-1:0];

    // Next-state logic: one shared counter serves hold, delay and timeout phases.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stage_next = stage_reg;
        rst_n_next = rst_n_reg;
        busy_next  = busy_reg;
        done_next  = done_reg;
        terr_next  = terr_reg;
        advance    = 1'b0;

        unique case (state_reg)
            ST_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    cnt_next   = '0;
                    stage_next = '0;
                    state_next = ST_DELAY;
                end else begin
                    cnt_next = cnt_reg + W_CNT'(1);
                end
            end
            ST_DELAY: begin
                if (cnt_reg == DELAY_LAST) begin
                    rst_n_next[idx] = 1'b1;
                    cnt_next        = '0;
                    if (USE_READY[idx]) begin
                        state_next = ST_WAIT_RDY;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + W_CNT'(1);
                end
            end
            ST_WAIT_RDY: begin
                if (bus.chan_ready[idx]) begin
                    advance = 1'b1;
                end else if (READY_TIMEOUT != 0 && cnt_reg == TO_LAST) begin
                    // Give up on this channel but remember it for software.
                    terr_next = 1'b1;
                    advance   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + W_CNT'(1);
                end
            end
            ST_RUN: begin
            end
            default: state_next = ST_HOLD;
        endcase

        // Move to the next channel, or finish after the last one.
        if (advance) begin
            cnt_next = '0;
            if (stage_reg == LAST_STAGE) begin
                state_next = ST_RUN;
                busy_next  = 1'b0;
                done_next  = 1'b1;
            end else begin
                stage_next = stage_reg + SW'(1);
                state_next = ST_DELAY;
            end
        end

        // Software re-sequence overrides everything, from any state.
        if (bus.req_reset) begin
            state_next = ST_HOLD;
            cnt_next   = '0;
            stage_next = '0;
            rst_n_next = '0;
            busy_next  = 1'b1;
            done_next  = 1'b0;
            terr_next  = 1'b0;
        end
    end

    // State and output registers; rst_sys wins over req_reset.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_reg <= ST_HOLD;
            cnt_reg   <= '0;
            stage_reg <= '0;
            rst_n_reg <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            terr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            stage_reg <= stage_next;
            rst_n_reg <= rst_n_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            terr_reg  <= terr_next;
        end
    end

    assign bus.rst_n_out   = rst_n_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.timeout_err = terr_reg;
    assign bus.stage       = stage_reg;

endmodule
